keccak_squeeze: RTL
===================

// Module: keccak_squeeze
// PURPOSE
// Squeeze-side sponge stage. Takes a permuted Keccak state from the round core and
// streams the rate portion out one lane per beat. When the requested length exceeds
// one rate block, it asks the core for another permutation (SHAKE extendable output).
// It sits between the permutation core and the digest output port.
// PARAMETERS
// w           64   lane width in bits (multiple of 8); state is 25 lanes
// RATE_LANES  17   rate in lanes (18/17/13/9 for SHA3-224/256/384/512; 21/17 for SHAKE128/256)
// LEN_W       16   width of the byte-length field
// PORTS
// clk        in   1                     clock
// reset      in   1                     synchronous, active-high reset
// cmd_valid  in   1                     squeeze request valid
// cmd_ready  out  1                     request accepted (high in IDLE only)
// cmd_bytes  in   LEN_W                 total output bytes requested
// s_valid    in   1                     permuted state valid
// s_ready    out  1                     state accepted (high in WAIT_S only)
// s_state    in   [4:0][4:0][w-1:0]     state, indexed [x][y], same lane layout as round core
// perm_req   out  1                     one-cycle pulse: permute again and resend state
// m_valid    out  1                     output lane valid
// m_ready    in   1                     downstream accepts lane
// m_data     out  w                     lane s_state[k%5][k/5]; lane bit/byte order unchanged
// m_keep     out  w/8                   byte enables; bit b covers m_data[8b+:8]
// m_last     out  1                     final beat of the request
// done       out  1                     one-cycle pulse when request completes
// BEHAVIOUR
// - Reset: FSM=IDLE; cmd_ready=1; s_ready=m_valid=m_last=perm_req=done=0; m_data=0; m_keep=0.
// - Reset mid-operation aborts the request. The captured state and counters are discarded. No done pulse.
// - FSM IDLE -> WAIT_S on cmd_valid&&cmd_ready with cmd_bytes>0. Latch rem=cmd_bytes; lane k=0.
// - cmd_bytes==0: stay in IDLE and pulse done the next cycle. No state handshake, no output.
// - WAIT_S: s_ready=1. On s_valid, capture the RATE_LANES rate lanes into a register, set k=0, go to DRAIN.
//   s_valid outside WAIT_S is ignored.
// - DRAIN: m_valid=1 from the cycle after capture (latency 1). m_data = captured lane k.
//   m_data, m_keep and m_last hold stable while m_valid && !m_ready.
// - Beat transfer (m_valid&&m_ready): rem -= min(rem, w/8); k++.
// - m_keep = all ones if rem>=w/8, else (1<<rem)-1, with rem taken before the beat.
// - m_last=1 iff rem<=w/8 on that beat. On transfer of the last beat: pulse done, go to IDLE.
// - Rate exhausted (k==RATE_LANES-1 transferred, not last): go to REQ.
//   REQ asserts perm_req for exactly one cycle, then goes to WAIT_S. k restarts at 0.
// - Exact fit (rem hits 0 on lane RATE_LANES-1): finish normally; perm_req is never asserted.
// - rem and k never wrap. k is clog2(RATE_LANES) bits wide. rem is LEN_W bits wide.
// STRUCTURE
// - keccak_pkg holds: lane_t (logic [w-1:0]), state_t ([4:0][4:0] lane_t), and RATE_* lane
//   constants per variant.
// - Squeeze FSM enum lives locally.
// - No sub-module. Lane select is an inline mux over the rate register.
// TESTING
// - Lane k low byte=k, rest 0. RATE 17, cmd_bytes=32:
//   4 beats data 0..3, keep 0xFF, m_last on beat 4, done, no perm_req.
// - RATE 18, cmd_bytes=28: 4 beats; beat 4 keep=0x0F with m_last; done 1 cycle after.
// - RATE 21, cmd_bytes=200: 21 beats, perm_req pulse, second state (low byte 0x80+k):
//   beats 0x80..0x83, last keep 0xFF.
// - RATE 21, cmd_bytes=168 (exact fit): 21 beats, m_last on lane 20, perm_req never high.
// - m_ready random 50%, cmd_bytes=64: data and keep stable under stall; 8 beats in order, none lost or duplicated.
// - cmd_bytes=0: done next cycle, m_valid and s_ready stay 0.
// - Reset during beat 2: next cycle m_valid=0, s_ready=0, cmd_ready=1, no done.
//   A new request then runs cleanly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak types and rate constants for the sponge pipeline.
package keccak_pkg;

   // Lane width of the standard Keccak-f[1600] permutation.
   localparam int LANE_W = 64;

   typedef logic [LANE_W-1:0] lane_t;
   // Indexed [x][y], matching the round core lane layout.
   typedef lane_t [4:0][4:0]  state_t;

   // Rate in lanes for each supported variant.
   localparam int RATE_SHA3_224 = 18;
   localparam int RATE_SHA3_256 = 17;
   localparam int RATE_SHA3_384 = 13;
   localparam int RATE_SHA3_512 = 9;
   localparam int RATE_SHAKE128 = 21;
   localparam int RATE_SHAKE256 = 17;

   // Default width of the byte-length field.
   localparam int LEN_W_DEF = 16;

endpackage

// File: rtl/keccak_squeeze.sv
// Squeeze stage: captures the rate part of a permuted state and streams it
// out one lane per beat, requesting further permutations for long outputs.
module keccak_squeeze
   import keccak_pkg::*;
#(
   parameter int w          = LANE_W,
   parameter int RATE_LANES = RATE_SHAKE256,
   parameter int LEN_W      = LEN_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [LEN_W-1:0]         cmd_bytes,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [4:0][4:0][w-1:0]   s_state,
   output logic                     perm_req,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [w-1:0]             m_data,
   output logic [w/8-1:0]           m_keep,
   output logic                     m_last,
   output logic                     done
);

   localparam int BYTES = w / 8;
   localparam int KW    = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_S,
      S_DRAIN,
      S_REQ
   } sq_state_e;

   sq_state_e                      state_q, state_d;
   logic [LEN_W-1:0]               rem_q, rem_d;
   logic [KW-1:0]                  k_q, k_d;
   logic [RATE_LANES-1:0][w-1:0]   rate_q, rate_d;
   logic                           done_q, done_d;

   logic                           drain;
   logic                           beat_last;
   logic                           xfer;

   // Capacity lanes are never emitted; fold them so they are visibly consumed.
   logic                           unused_state;
   assign unused_state = ^s_state;

   assign drain     = (state_q == S_DRAIN);
   // rem is taken before the beat, so a beat is last when it covers the rest.
   assign beat_last = (rem_q <= LEN_W'(BYTES));
   assign xfer      = drain && m_ready;

   // State, counters and the captured rate block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         k_q     <= '0;
         rate_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         k_q     <= k_d;
         rate_q  <= rate_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: command accept, state capture, beat accounting.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      k_d     = k_q;
      rate_d  = rate_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_bytes == '0) begin
                  // Empty request completes immediately, no state handshake.
                  done_d = 1'b1;
               end else begin
                  rem_d   = cmd_bytes;
                  k_d     = '0;
                  state_d = S_WAIT_S;
               end
            end
         end

         S_WAIT_S: begin
            if (s_valid) begin
               // Rate lane k sits at x = k%5, y = k/5.
               for (int i = 0; i < RATE_LANES; i++) begin
                  rate_d[i] = s_state[i % 5][i / 5];
               end
               k_d     = '0;
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (m_ready) begin
               if (beat_last) begin
                  // Covers the exact-fit case on the final rate lane too.
                  rem_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  rem_d = rem_q - LEN_W'(BYTES);
                  if (k_q == KW'(RATE_LANES - 1)) begin
                     k_d     = '0;
                     state_d = S_REQ;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end
            end
         end

         S_REQ: begin
            // Single cycle here gives a one-cycle perm_req pulse.
            state_d = S_WAIT_S;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Byte enables: byte b valid while more than b bytes remain.
   always_comb begin
      m_keep = '0;
      for (int b = 0; b < BYTES; b++) begin
         m_keep[b] = drain && (rem_q > LEN_W'(b));
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign s_ready   = (state_q == S_WAIT_S);
   assign perm_req  = (state_q == S_REQ);
   assign m_valid   = drain;
   assign m_data    = drain ? rate_q[k_q] : '0;
   assign m_last    = drain && beat_last;
   assign done      = done_q;

   // xfer is the beat handshake; kept as a named term for readability.
   logic unused_xfer;
   assign unused_xfer = xfer;

endmodule
